// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between the core (requester 0) and a loader/debug master (requester 1).
// One access at a time: RAM driven ACCESS_CYCLES cycles, then a one-cycle ACK; round-robin on ties.
module mem_port_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     M0_REQ,
    input  logic                     M0_WE,
    input  logic [ADDRESS_WIDTH-1:0] M0_ADDR,
    input  logic [DATA_WIDTH-1:0]    M0_WDATA,
    input  logic [1:0]               M0_SEL,
    output logic                     M0_ACK,
    output logic [DATA_WIDTH-1:0]    M0_RDATA,
    input  logic                     M1_REQ,
    input  logic                     M1_WE,
    input  logic [ADDRESS_WIDTH-1:0] M1_ADDR,
    input  logic [DATA_WIDTH-1:0]    M1_WDATA,
    input  logic [1:0]               M1_SEL,
    output logic                     M1_ACK,
    output logic [DATA_WIDTH-1:0]    M1_RDATA,
    output logic [ADDRESS_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0]    MEM_WDATA,
    output logic                     MEM_W_EN,
    output logic [1:0]               MEM_SEL,
    input  logic [DATA_WIDTH-1:0]    MEM_RDATA
);
    localparam int CW = $clog2(ACCESS_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [CW-1:0]            r_cnt;
    logic                     r_owner;
    logic                     r_last_grant;
    logic                     r_m0_ack;
    logic                     r_m1_ack;
    logic [DATA_WIDTH-1:0]    r_m0_rdata;
    logic [DATA_WIDTH-1:0]    r_m1_rdata;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_wdata;
    logic                     r_mem_w_en;
    logic [1:0]               r_mem_sel;
    logic                     w_grant_vld;
    logic                     w_grant_id;
    logic                     w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_next_state = r_state;
        w_grant_vld  = 1'b0;
        w_grant_id   = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (M0_REQ && M1_REQ) begin
                    w_grant_vld = 1'b1;
                    w_grant_id  = ~r_last_grant;
                end else if (M0_REQ || M1_REQ) begin
                    w_grant_vld = 1'b1;
                    w_grant_id  = M1_REQ;
                end
                if (w_grant_vld) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (w_cnt_zero) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_w_en   <= 1'b0;
            r_mem_sel    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_owner     <= w_grant_id;
                        r_mem_addr  <= w_grant_id ? M1_ADDR  : M0_ADDR;
                        r_mem_wdata <= w_grant_id ? M1_WDATA : M0_WDATA;
                        r_mem_w_en  <= w_grant_id ? M1_WE    : M0_WE;
                        r_mem_sel   <= w_grant_id ? M1_SEL   : M0_SEL;
                        r_cnt       <= CW'(ACCESS_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        // Last RAM cycle: read data is valid on the port now.
                        r_mem_w_en   <= 1'b0;
                        r_last_grant <= r_owner;
                        if (r_owner) begin
                            r_m1_ack <= 1'b1;
                            if (!r_mem_w_en) begin
                                r_m1_rdata <= MEM_RDATA;
                            end
                        end else begin
                            r_m0_ack <= 1'b1;
                            if (!r_mem_w_en) begin
                                r_m0_rdata <= MEM_RDATA;
                            end
                        end
                    end
                end
                DONE: begin
                    r_m0_ack <= 1'b0;
                    r_m1_ack <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign M0_ACK    = r_m0_ack;
    assign M1_ACK    = r_m1_ack;
    assign M0_RDATA  = r_m0_rdata;
    assign M1_RDATA  = r_m1_rdata;
    assign MEM_ADDR  = r_mem_addr;
    assign MEM_WDATA = r_mem_wdata;
    assign MEM_W_EN  = r_mem_w_en;
    assign MEM_SEL   = r_mem_sel;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter instances (1 and 3 access cycles) driven by random and directed request rounds;
// a transaction-level model predicts grant order, ACK timing and read data into a scoreboard.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          rq;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sel;
        int          g;
    } op_t;

    typedef struct {
        int          rq;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  sel;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int N = (k == 0) ? 1 : 3;

        logic        rst;
        logic        req [2];
        logic        we [2];
        logic [31:0] addr [2];
        logic [31:0] wdata [2];
        logic [1:0]  sel [2];
        logic        ack0, ack1;
        logic [31:0] rd0, rd1;
        logic [1:0]  ack;
        logic [31:0] rdata [2];
        logic [31:0] mem_addr, mem_wdata, mem_rdata;
        logic        mem_w_en;
        logic [1:0]  mem_sel;
        logic [31:0] ram [64];
        logic [31:0] refmem [64];
        bit          fin = 1'b0;
        int          last_grant = 1;
        op_t         ops [$];
        exp_t        sbq [$];

        assign ack      = {ack1, ack0};
        assign rdata[0] = rd0;
        assign rdata[1] = rd1;
        assign mem_rdata = ram[mem_addr[7:2]];

        mem_port_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .ACCESS_CYCLES(N)) dut (
            .CLK(clk), .RST(rst),
            .M0_REQ(req[0]), .M0_WE(we[0]), .M0_ADDR(addr[0]), .M0_WDATA(wdata[0]),
            .M0_SEL(sel[0]), .M0_ACK(ack0), .M0_RDATA(rd0),
            .M1_REQ(req[1]), .M1_WE(we[1]), .M1_ADDR(addr[1]), .M1_WDATA(wdata[1]),
            .M1_SEL(sel[1]), .M1_ACK(ack1), .M1_RDATA(rd1),
            .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_W_EN(mem_w_en),
            .MEM_SEL(mem_sel), .MEM_RDATA(mem_rdata)
        );

        initial begin : ram_model
            logic [31:0] v;
            for (int i = 0; i < 64; i++) begin
                v = $urandom;
                ram[i] <= v;
                refmem[i] = v;
            end
            forever begin
                @(posedge clk);
                if (mem_w_en) ram[mem_addr[7:2]] <= mem_wdata;
            end
        end

        function automatic string nm(input string s);
            return $sformatf("n%0d_%s", N, s);
        endfunction

        task automatic add_op(input int r, input bit w, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] s);
            op_t o;
            o.rq = r; o.we = w; o.addr = a; o.wdata = d; o.sel = s; o.g = 0;
            ops.push_back(o);
        endtask

        function automatic int next_of(input int r, input int from);
            for (int i = from; i < ops.size(); i++)
                if (ops[i].rq == r) return i;
            return -1;
        endfunction

        // Every requester re-requests as soon as allowed, so each arbitration sees
        // all requesters that still have work; ties go to the one not served last.
        task automatic plan(input int t0);
            int   nxt [2];
            int   g;
            int   w;
            exp_t e;
            g = t0 + 1;
            nxt[0] = next_of(0, 0);
            nxt[1] = next_of(1, 0);
            while (nxt[0] >= 0 || nxt[1] >= 0) begin
                if (nxt[0] >= 0 && nxt[1] >= 0) w = (last_grant == 1) ? 0 : 1;
                else                            w = (nxt[0] >= 0) ? 0 : 1;
                ops[nxt[w]].g = g;
                e.rq = w; e.we = ops[nxt[w]].we; e.addr = ops[nxt[w]].addr;
                e.wdata = ops[nxt[w]].wdata; e.sel = ops[nxt[w]].sel; e.cyc = g + N;
                if (e.we) refmem[e.addr[7:2]] = e.wdata;
                e.rdata = refmem[e.addr[7:2]];
                sbq.push_back(e);
                last_grant = w;
                g = g + N + 2;
                nxt[w] = next_of(w, nxt[w] + 1);
            end
        endtask

        task automatic scramble(input int r);
            addr[r]  = $urandom;
            we[r]    = ~we[r];
            wdata[r] = $urandom;
            sel[r]   = 2'($urandom_range(0, 3));
        endtask

        task automatic drive_req(input int r);
            int to;
            for (int i = 0; i < ops.size(); i++) begin
                if (ops[i].rq != r) continue;
                we[r] = ops[i].we; addr[r] = ops[i].addr;
                wdata[r] = ops[i].wdata; sel[r] = ops[i].sel;
                req[r] = 1'b1;
                while (cyc < ops[i].g) @(negedge clk);
                scramble(r);
                to = 0;
                while (!ack[r] && to < 40) begin
                    @(negedge clk);
                    to++;
                end
                if (!ack[r]) flag(nm($sformatf("ack_timeout_req%0d", r)));
                req[r] = 1'b0;
                scramble(r);
                @(negedge clk);
            end
        endtask

        task automatic run_round();
            plan(cyc);
            fork
                drive_req(0);
                drive_req(1);
            join
            ops.delete();
        endtask

        task automatic add_rand(input int r);
            logic [31:0] a;
            a = $urandom;
            a[7:2] = 6'($urandom_range(0, 15));
            add_op(r, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)));
        endtask

        task automatic check_all_zero(input string tag);
            chk(nm({tag, "_m0_ack"}), 32'(ack0), 0);
            chk(nm({tag, "_m1_ack"}), 32'(ack1), 0);
            chk(nm({tag, "_m0_rdata"}), rd0, 0);
            chk(nm({tag, "_m1_rdata"}), rd1, 0);
            chk(nm({tag, "_mem_addr"}), mem_addr, 0);
            chk(nm({tag, "_mem_wdata"}), mem_wdata, 0);
            chk(nm({tag, "_mem_w_en"}), 32'(mem_w_en), 0);
            chk(nm({tag, "_mem_sel"}), 32'(mem_sel), 0);
        endtask

        task automatic reset_mid_write();
            int          g;
            logic [31:0] d;
            d = $urandom;
            g = cyc + 1;
            we[0] = 1'b1; addr[0] = 32'h30; wdata[0] = d; sel[0] = 2'b11; req[0] = 1'b1;
            while (cyc < g + ((N > 1) ? 1 : 0)) @(negedge clk);
            rst = 1'b1;
            req[0] = 1'b0;
            @(negedge clk);
            check_all_zero("midrst");
            @(negedge clk);
            rst = 1'b0;
            refmem[32'h30 >> 2] = d;
            last_grant = 1;
            repeat (N + 3) @(negedge clk);
        endtask

        initial begin : mon
            exp_t        e;
            int          wen_cnt;
            logic [31:0] exp_rd [2];
            wen_cnt = 0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    wen_cnt = 0;
                    exp_rd[0] = '0;
                    exp_rd[1] = '0;
                end else begin
                    if (mem_w_en) wen_cnt++;
                    if (ack0 && ack1) begin
                        flag(nm("both_acks_high"));
                    end else if (ack != 2'b00) begin
                        if (sbq.size() == 0) begin
                            flag(nm("unexpected_ack"));
                        end else begin
                            e = sbq.pop_front();
                            chk(nm("ack_owner"), 32'(ack[1]), 32'(e.rq));
                            chk(nm("ack_cycle"), cyc, e.cyc);
                            chk(nm("mem_addr"), mem_addr, e.addr);
                            chk(nm("mem_sel"), 32'(mem_sel), 32'(e.sel));
                            chk(nm("w_en_cycles"), wen_cnt, e.we ? N : 0);
                            if (e.we) chk(nm("mem_wdata"), mem_wdata, e.wdata);
                            else      exp_rd[e.rq] = e.rdata;
                            chk(nm("m0_rdata"), rd0, exp_rd[0]);
                            chk(nm("m1_rdata"), rd1, exp_rd[1]);
                        end
                        wen_cnt = 0;
                    end
                end
            end
        end

        initial begin : stim
            int n0, n1;
            rst = 1'b1;
            for (int r = 0; r < 2; r++) begin
                req[r] = 1'b0; we[r] = 1'b0; addr[r] = '0; wdata[r] = '0; sel[r] = '0;
            end
            repeat (3) @(negedge clk);
            check_all_zero("reset");
            rst = 1'b0;
            @(negedge clk);

            add_op(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11); run_round();
            add_op(0, 1'b0, 32'h10, 32'h0, 2'b11);        run_round();

            add_op(0, 1'b0, 32'h20, 32'h0, 2'b11);
            add_op(1, 1'b0, 32'h40, 32'h0, 2'b11);
            run_round();

            for (int i = 0; i < 3; i++) begin
                add_rand(0);
                add_rand(1);
            end
            run_round();

            add_op(1, 1'b0, 32'h8, 32'h0, 2'b11); run_round();
            add_op(0, 1'b0, 32'h10, 32'h0, 2'b11); run_round();

            reset_mid_write();
            add_op(0, 1'b0, 32'h30, 32'h0, 2'b11);
            add_op(1, 1'b0, 32'h10, 32'h0, 2'b01);
            run_round();

            repeat (30) begin
                n0 = $urandom_range(0, 2);
                n1 = $urandom_range(0, 2);
                if (n0 + n1 == 0) n0 = 1;
                for (int i = 0; i < 2; i++) begin
                    if (i < n0) add_rand(0);
                    if (i < n1) add_rand(1);
                end
                run_round();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end

            repeat (N + 4) @(negedge clk);
            chk(nm("scoreboard_drained"), sbq.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        fork
            wait (g_inst[0].fin && g_inst[1].fin);
            begin
                #400000;
                flag("watchdog_expired");
            end
        join_any
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter sharing the single unified RAM port (Data, Addr, W_EN, sel, Output_Data) between the Multi_Cyclic_MIPS core (requester 0) and a program loader/debug master (requester 1).
- Sits between both masters and RAM in Top.
- Latches one request at a time, drives RAM for a fixed number of cycles, then returns read data with a one-cycle ACK.
- Round-robin fairness; requester 0 wins the first tie after reset.

Parameters:
ADDRESS_WIDTH, 32, address width of requesters and RAM.
DATA_WIDTH, 32, data width of requesters and RAM.
ACCESS_CYCLES, 1, cycles RAM is driven per access (>=1); counter width = clog2(ACCESS_CYCLES)+1.

Ports:
CLK  input  1  clock, all state on rising edge.
RST  input  1  reset, synchronous, active-high.
M0_REQ  input  1  requester 0 access request, held until M0_ACK.
M0_WE  input  1  1 = write, 0 = read.
M0_ADDR  input  ADDRESS_WIDTH  access address.
M0_WDATA  input  DATA_WIDTH  write data.
M0_SEL  input  2  byte/half/word select, passed to RAM sel.
M0_ACK  output  1  one-cycle completion pulse.
M0_RDATA  output  DATA_WIDTH  read data, valid with M0_ACK.
M1_REQ, M1_WE, M1_ADDR, M1_WDATA, M1_SEL, M1_ACK, M1_RDATA: same as M0_*, for requester 1.
MEM_ADDR  output  ADDRESS_WIDTH  to RAM Addr.
MEM_WDATA  output  DATA_WIDTH  to RAM Data.
MEM_W_EN  output  1  to RAM W_EN.
MEM_SEL  output  2  to RAM sel.
MEM_RDATA  input  DATA_WIDTH  from RAM Output_Data.

Behaviour:
- Reset (sync, RST=1 at edge): state IDLE; all outputs 0 (ACKs, RDATAs, MEM_*); owner=0; last_grant=1 so requester 0 wins the first tie. Reset mid-access aborts it: no ACK is issued, and MEM_W_EN is 0 from that edge.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No REQ: stay IDLE.
  - One REQ: grant it.
  - Both REQ: grant the requester that is not last_grant.
  - On grant: latch WE/ADDR/WDATA/SEL into MEM_* (MEM_W_EN=WE), owner=winner, cnt=ACCESS_CYCLES-1, next state BUSY.
- BUSY:
  - MEM_* hold the latched values; later requester input changes are ignored.
  - cnt>0: decrement.
  - cnt==0: capture MEM_RDATA into owner's RDATA (reads only; writes leave RDATA unchanged); assert owner's ACK; MEM_W_EN<=0; last_grant<=owner; next state DONE.
- DONE: ACK is high for exactly this one cycle. REQs are not sampled. ACK<=0, next state IDLE.
- Requester protocol: drop REQ on the edge after it sees ACK. A REQ still high in IDLE is a new request.
- Timing, sample edge E0 in IDLE:
  - MEM_* valid from E0 to E_N, N=ACCESS_CYCLES.
  - ACK high between E_N and E_N+1.
  - Next arbitration at E_N+2.
  - Throughput: one access per N+2 cycles.
- MEM_W_EN is high for all N BUSY cycles, so RAM rewrites identical data N times, which is harmless.
- ACK is never asserted to both requesters at once. The non-owner's ACK and RDATA are untouched.
- Unused MEM_* bits hold their last values between accesses, except MEM_W_EN, which is 0 outside BUSY.

Test Plan:
1. Reset, then M0 write 0xDEADBEEF to 0x10, SEL=word, N=1 -> MEM_W_EN=1 for one cycle after E0; M0_ACK at E1; a following M0 read of 0x10 returns M0_RDATA=0xDEADBEEF with ACK.
2. After reset, M0 and M1 REQ on the same edge (M0 addr 0x20, M1 addr 0x40) -> MEM_ADDR=0x20 first, M0_ACK; then MEM_ADDR=0x40, M1_ACK; M1 idle throughout first access.
3. Both REQ held high continuously (re-asserted after each ACK) for 6 accesses -> grant order 0,1,0,1,0,1; ACK spacing exactly 3 cycles.
4. ACCESS_CYCLES=3, M1 read 0x8 -> MEM_ADDR=0x8 for 3 cycles; M1_ACK exactly 3 edges after sample edge; M1_RDATA equals RAM word at 0x8.
5. M0 write in BUSY with ACCESS_CYCLES=3, RST high on second BUSY cycle -> no M0_ACK; all outputs 0 next cycle; a following simultaneous request grants M0 first.
6. M0 changes M0_ADDR from 0x10 to 0x99 and M0_WE from 0 to 1 while BUSY -> MEM_ADDR stays 0x10 and MEM_W_EN stays 0 until ACK.
